// File: rtl/peripheral_divmod.sv
// Memory-mapped serial restoring divider: quotient and remainder, signed or unsigned,
// one quotient bit per clock, with busy/done/dz/ovf status and a level interrupt.
module peripheral_divmod #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic [3:0]       addr,
    input  logic             rd,
    input  logic             wr,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             irq
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, q_reg, r_reg;
    logic             signed_mode, irq_en;
    logic             done, dz, ovf;
    logic [WIDTH-1:0] rem, quo, div;
    logic             sign_q, sign_r;
    logic [CW-1:0]    cnt;

    logic             wr_en, rd_en, busy, start;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_sh, diff;
    logic             no_borrow;
    logic             ovf_case;
    logic [WIDTH-1:0] rdata;

    // A simultaneous read and write strobe is treated as a read only.
    assign wr_en = cs & wr & ~rd;
    assign rd_en = cs & rd;
    assign busy  = (state != S_IDLE);
    assign start = wr_en && (addr == 4'h4) && d_in[0] && !busy;
    assign irq   = done & irq_en;

    assign a_abs = (signed_mode && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    assign b_abs = (signed_mode && b_reg[WIDTH-1]) ? -b_reg : b_reg;

    assign rem_sh    = {rem, quo[WIDTH-1]};
    assign no_borrow = (rem_sh >= {1'b0, div});
    assign diff      = rem_sh - {1'b0, div};

    // Signed MIN / -1: the magnitude path already yields Q = MIN, R = 0; only the flag is extra.
    assign ovf_case = signed_mode && (a_reg == {1'b1, {(WIDTH-1){1'b0}}}) && (b_reg == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_LOAD;
            S_LOAD: state_next = (b_reg == '0) ? S_DONE : S_RUN;
            S_RUN:  if (cnt == CW'(WIDTH - 1)) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (addr)
            4'h0: rdata = a_reg;
            4'h2: rdata = b_reg;
            4'h4: rdata[2:1] = {irq_en, signed_mode};
            4'h6: rdata = q_reg;
            4'h8: rdata = r_reg;
            4'hA: rdata[3:0] = {ovf, dz, done, busy};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            signed_mode <= 1'b0;
            irq_en      <= 1'b0;
            done        <= 1'b0;
            dz          <= 1'b0;
            ovf         <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            div         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            cnt         <= '0;
            d_out       <= '0;
        end else begin
            if (wr_en && !busy) begin
                case (addr)
                    4'h0: a_reg <= d_in;
                    4'h2: b_reg <= d_in;
                    4'h4: begin
                        signed_mode <= d_in[1];
                        irq_en      <= d_in[2];
                    end
                    default: ;
                endcase
            end
            if (start) begin
                done <= 1'b0;
                dz   <= 1'b0;
                ovf  <= 1'b0;
            end
            if (rd_en) begin
                d_out <= rdata;
                if (addr == 4'hA) done <= 1'b0;
            end
            // A completion on the same edge as a STATUS read wins, so the event is not lost.
            case (state)
                S_LOAD: begin
                    rem    <= '0;
                    quo    <= a_abs;
                    div    <= b_abs;
                    cnt    <= '0;
                    sign_q <= signed_mode & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                    sign_r <= signed_mode & a_reg[WIDTH-1];
                    if (b_reg == '0) begin
                        q_reg <= '1;
                        r_reg <= a_reg;
                        dz    <= 1'b1;
                    end
                end
                S_RUN: begin
                    rem <= no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], no_borrow};
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    q_reg <= sign_q ? -quo : quo;
                    r_reg <= sign_r ? -rem : rem;
                    if (ovf_case) ovf <= 1'b1;
                end
                S_DONE: done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_divmod.sv
// Bench for peripheral_divmod: a 16-bit and a 32-bit instance share the bus, selected by sel;
// results are compared against a plain-arithmetic division model.
module tb_peripheral_divmod;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0, sel = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] d_in = 32'h0;
    logic [15:0] d_out16;
    logic [31:0] d_out32;
    logic        irq16, irq32;
    logic        cs16, cs32;
    logic [31:0] d_out_m;
    logic        irq_m;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign cs16    = cs & ~sel;
    assign cs32    = cs & sel;
    assign d_out_m = sel ? d_out32 : {16'h0, d_out16};
    assign irq_m   = sel ? irq32 : irq16;

    peripheral_divmod #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .cs(cs16), .addr(addr), .rd(rd), .wr(wr),
        .d_in(d_in[15:0]), .d_out(d_out16), .irq(irq16)
    );

    peripheral_divmod #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .cs(cs32), .addr(addr), .rd(rd), .wr(wr),
        .d_in(d_in), .d_out(d_out32), .irq(irq32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        d = d_out_m;
    endtask

    task automatic wait_irq(output int cyc);
        cyc = 0;
        while (!irq_m && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Reference: truncating division on sign-extended values; divide by zero gives all ones / A.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input bit sgn, input int w,
                         output logic [31:0] q, output logic [31:0] r, output bit dz, output bit ovf);
        longint m, sa, sb;
        m   = (longint'(1) << w) - 1;
        dz  = 1'b0;
        ovf = 1'b0;
        if (b == 0) begin
            q  = 32'(m);
            r  = a;
            dz = 1'b1;
        end else if (sgn) begin
            sa  = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
            sb  = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
            q   = 32'((sa / sb) & m);
            r   = 32'((sa % sb) & m);
            ovf = (sa == -(longint'(1) << (w - 1))) && (sb == -1);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] q, r, rd_v;
        bit dz, ovf;
        int w, cyc;
        w = sel ? 32 : 16;
        model(a, b, sgn, w, q, r, dz, ovf);
        bus_write(4'h0, a);
        bus_write(4'h2, b);
        bus_write(4'h4, {29'h0, 1'b1, sgn, 1'b1});
        wait_irq(cyc);
        check({tag, " latency"}, cyc, dz ? 2 : w + 3);
        bus_read(4'hA, rd_v);
        check({tag, " status"}, rd_v, {28'h0, ovf, dz, 1'b1, 1'b0});
        check({tag, " irq cleared"}, {31'h0, irq_m}, 32'h0);
        bus_read(4'h6, rd_v);
        check({tag, " q"}, rd_v, q);
        bus_read(4'h8, rd_v);
        check({tag, " r"}, rd_v, r);
    endtask

    initial begin
        logic [31:0] v, a, b;
        int cyc, k;
        bit sgn;

        // Reset
        repeat (3) @(negedge clk);
        check("reset d_out", {16'h0, d_out16}, 32'h0);
        check("reset irq", {31'h0, irq16}, 32'h0);
        rst = 1'b1;
        for (int i = 0; i <= 10; i += 2) begin
            bus_read(4'(i), v);
            check($sformatf("reset reg %0h", i), v, 32'h0);
        end

        // Directed cases
        run_op("unsigned 10/4", 32'd10, 32'd4, 1'b0);
        run_op("signed -7/2", 32'hFFF9, 32'd2, 1'b1);
        run_op("signed 7/-2", 32'd7, 32'hFFFE, 1'b1);
        run_op("div zero", 32'd35, 32'd0, 1'b0);
        run_op("overflow", 32'h8000, 32'hFFFF, 1'b1);
        run_op("ffff/1", 32'hFFFF, 32'd1, 1'b0);
        run_op("signed div zero", 32'hFFF0, 32'd0, 1'b1);

        // Interrupt disabled: done still sets, irq stays low
        bus_write(4'h0, 32'd10);
        bus_write(4'h2, 32'd4);
        bus_write(4'h4, 32'h1);
        repeat (19) @(negedge clk);
        check("irq disabled", {31'h0, irq16}, 32'h0);
        bus_read(4'hA, v);
        check("irq disabled status", v, 32'h2);
        bus_read(4'h4, v);
        check("ctrl readback", v, 32'h0);

        // Busy protection
        bus_write(4'h0, 32'd10);
        bus_write(4'h2, 32'd4);
        bus_write(4'h4, 32'h5);
        bus_write(4'h0, 32'd99);
        bus_write(4'h4, 32'h7);
        bus_read(4'hA, v);
        check("busy status", v, 32'h1);
        wait_irq(cyc);
        check("busy irq seen", {31'h0, irq16}, 32'h1);
        bus_read(4'hA, v);
        check("busy done status", v, 32'h2);
        bus_read(4'hA, v);
        check("done cleared", v, 32'h0);
        bus_read(4'h6, v);
        check("busy q", v, 32'd2);
        bus_read(4'h8, v);
        check("busy r", v, 32'd2);
        bus_read(4'h0, v);
        check("busy a kept", v, 32'd10);
        bus_read(4'h4, v);
        check("busy ctrl kept", v, 32'h4);
        bus_write(4'h0, 32'd77);
        bus_read(4'h6, v);
        check("q after a write", v, 32'd2);
        bus_read(4'hC, v);
        check("unmapped read", v, 32'h0);

        // Randomized 16-bit
        for (int i = 0; i < 40; i++) begin
            a   = $urandom & 32'hFFFF;
            b   = $urandom & 32'hFFFF;
            sgn = 1'($urandom_range(0, 1));
            k   = $urandom_range(0, 9);
            if (k == 0) b = 32'h0;
            else if (k == 1) b = 32'hFFFF;
            else if (k == 2) a = 32'h8000;
            else if (k < 6) b = $urandom_range(1, 20);
            run_op($sformatf("rand16 %0d", i), a, b, sgn);
        end

        // Reset mid-run
        bus_write(4'h0, 32'd10);
        bus_write(4'h2, 32'd4);
        bus_write(4'h4, 32'h5);
        bus_read(4'hA, v);
        check("midrun busy", v, 32'h1);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrun d_out", {16'h0, d_out16}, 32'h0);
        check("midrun irq", {31'h0, irq16}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        bus_read(4'hA, v);
        check("midrun status", v, 32'h0);
        bus_read(4'h0, v);
        check("midrun a", v, 32'h0);
        bus_read(4'h6, v);
        check("midrun q", v, 32'h0);
        bus_read(4'h4, v);
        check("midrun ctrl", v, 32'h0);

        // 32-bit instance
        sel = 1'b1;
        run_op("w32 ffffffff/3", 32'hFFFFFFFF, 32'd3, 1'b0);
        run_op("w32 overflow", 32'h80000000, 32'hFFFFFFFF, 1'b1);
        for (int i = 0; i < 10; i++) begin
            a   = $urandom;
            b   = (i < 5) ? 32'($urandom_range(1, 1000)) : $urandom;
            sgn = 1'($urandom_range(0, 1));
            run_op($sformatf("rand32 %0d", i), a, b, sgn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
